// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: turns UART receiver bytes into 16-bit commands for the
// Knight's Tour command processor. The high byte arrives first. A partial
// command is dropped after an inter-byte timeout. An unacknowledged command
// that gets overwritten is flagged.
// Optional build macro CMD_CHKSUM_EN adds a third checksum byte per command.
// The checksum byte must equal high ^ low ^ 8'hFF.
module uart_cmd_framer #(
    parameter int TIMEOUT_CLKS = 52080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        ovr_err,
    output logic        to_err,
    output logic        chk_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CLKS - 1);

`ifdef CMD_CHKSUM_EN
    typedef enum logic [1:0] {WAIT_HI, WAIT_LO, WAIT_CHK} state_t;
`else
    typedef enum logic [1:0] {WAIT_HI, WAIT_LO} state_t;
`endif

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_hiByte;
    logic [15:0]       r_cmd;
    logic              r_cmdRdy;
    logic              r_ovrErr;
    logic              r_toErr;
    logic              w_terminal;
    logic              w_loadHi;
    logic              w_complete;
    logic              w_timeout;
    logic [15:0]       w_newCmd;
`ifdef CMD_CHKSUM_EN
    logic [7:0]        r_loByte;
    logic              r_chkErr;
    logic              w_loadLo;
    logic              w_chkBad;
`endif

    // Every byte offered by the receiver is taken in the same cycle, so the ack is just rdy.
    assign clr_rx_rdy = rx_rdy;
    assign w_terminal = (r_cnt == CNT_TERM);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_HI;
        else        r_state <= w_nextState;
    end

    // Next-state and per-cycle events. An accepted byte always beats a timeout.
    always_comb begin
        w_nextState = r_state;
        w_loadHi    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_newCmd    = {r_hiByte, rx_data};
`ifdef CMD_CHKSUM_EN
        w_loadLo    = 1'b0;
        w_chkBad    = 1'b0;
`endif
        case (r_state)
            WAIT_HI: begin
                if (rx_rdy) begin
                    w_loadHi    = 1'b1;
                    w_nextState = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
`ifdef CMD_CHKSUM_EN
                    w_loadLo    = 1'b1;
                    w_nextState = WAIT_CHK;
`else
                    w_complete  = 1'b1;
                    w_nextState = WAIT_HI;
`endif
                end else if (w_terminal) begin
                    w_timeout   = 1'b1;
                    w_nextState = WAIT_HI;
                end
            end
`ifdef CMD_CHKSUM_EN
            WAIT_CHK: begin
                w_newCmd = {r_hiByte, r_loByte};
                if (rx_rdy) begin
                    if (rx_data == (r_hiByte ^ r_loByte ^ 8'hFF)) w_complete = 1'b1;
                    else                                          w_chkBad   = 1'b1;
                    w_nextState = WAIT_HI;
                end else if (w_terminal) begin
                    w_timeout   = 1'b1;
                    w_nextState = WAIT_HI;
                end
            end
`endif
            default: w_nextState = WAIT_HI;
        endcase
    end

    // Inter-byte counter: cleared on any state change, runs only while part of a command is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    r_cnt <= '0;
        else if (w_nextState != r_state)               r_cnt <= '0;
        else if (r_state != WAIT_HI && !w_terminal)    r_cnt <= r_cnt + 1'b1;
    end

    // Byte holding registers; a timed-out high byte is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_hiByte <= 8'h00;
        else if (w_loadHi)  r_hiByte <= rx_data;
        else if (w_timeout) r_hiByte <= 8'h00;
    end

`ifdef CMD_CHKSUM_EN
    // Low byte is parked here until the checksum byte confirms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_loByte <= 8'h00;
        else if (w_loadLo) r_loByte <= rx_data;
    end
`endif

    // Command register and its SR ready flag; a completion wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd    <= 16'h0000;
            r_cmdRdy <= 1'b0;
        end else if (w_complete) begin
            r_cmd    <= w_newCmd;
            r_cmdRdy <= 1'b1;
        end else if (clr_cmd_rdy) begin
            r_cmdRdy <= 1'b0;
        end
    end

    // Registered one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovrErr <= 1'b0;
            r_toErr  <= 1'b0;
        end else begin
            r_ovrErr <= w_complete && r_cmdRdy && !clr_cmd_rdy;
            r_toErr  <= w_timeout;
        end
    end

`ifdef CMD_CHKSUM_EN
    // Checksum failure pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chkErr <= 1'b0;
        else        r_chkErr <= w_chkBad;
    end
    assign chk_err = r_chkErr;
`else
    assign chk_err = 1'b0;
`endif

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmdRdy;
    assign ovr_err = r_ovrErr;
    assign to_err  = r_toErr;

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
Controller sitting directly behind the UART receiver in the Knight's Tour command path. Consumes received bytes via the receiver's rdy/clr_rdy handshake and acknowledges each byte. Assembles pairs of bytes (high byte first) into 16-bit commands and presents them to the command processor with a cmd_rdy/clr_cmd_rdy handshake. Provides inter-byte timeout resynchronisation and overrun flagging.

Parameters:
TIMEOUT_CLKS, 52080, clocks allowed between bytes of one command before the partial command is discarded (default is about 2 byte times at 19200 baud, 50 MHz).

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  byte-available flag from the UART receiver
rx_data  input  8  received byte; valid while rx_rdy is high
clr_rx_rdy  output  1  byte acknowledge to the receiver; pulses for one cycle
cmd  output  16  assembled command, {high byte, low byte}
cmd_rdy  output  1  command valid; held until cleared
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
ovr_err  output  1  one-cycle pulse: new command overwrote an unacknowledged one
to_err  output  1  one-cycle pulse: inter-byte timeout, partial command dropped
chk_err  output  1  one-cycle pulse: checksum mismatch (macro only; tied 0 otherwise)

Behaviour:
- Single clock (clk). Asynchronous active-low reset (rst_n) for all state.
- Reset values: state WAIT_HI, cmd=16'h0000, cmd_rdy=0, clr_rx_rdy=0, ovr_err=0, to_err=0, chk_err=0, timeout counter=0, high-byte register=8'h00.
- Reset asserted mid-command discards the partial command and any pending cmd_rdy.
- Byte accept: in any state, when rx_rdy=1 in cycle T, rx_data is captured at the end of T and clr_rx_rdy=1 during T (combinational, exactly one cycle).
- The receiver drops rdy at T+1, so each byte is accepted exactly once. rx_rdy=1 on consecutive cycles after an acknowledge is not expected and is not filtered.
- State WAIT_HI: on accept, store byte as high byte, clear the timeout counter, go to WAIT_LO. The counter does not run in WAIT_HI.
- State WAIT_LO: the counter increments each cycle without an accepted byte.
  - On accept: cmd <= {high byte, rx_data}, set cmd_rdy, go to WAIT_HI.
  - If the counter reaches TIMEOUT_CLKS-1 with no accept: pulse to_err at the next cycle, discard the high byte, go to WAIT_HI. cmd and cmd_rdy are untouched.
  - An accept in the same cycle as the terminal count takes priority; no to_err.
- Counter width is $clog2(TIMEOUT_CLKS+1) bits. It never wraps; it clears on every state entry.
- Latency: cmd_rdy=1 and cmd valid in cycle T+1 after the low (or checksum) byte is accepted in cycle T.
- cmd_rdy is an SR flop. Set = command completion; reset = clr_cmd_rdy.
  - Simultaneous set and reset: set wins, cmd updates, no ovr_err.
  - Completion while cmd_rdy=1 and clr_cmd_rdy=0: cmd is overwritten, cmd_rdy stays 1, ovr_err pulses at T+1.
- cmd is stable whenever no completion occurs. It changes only on completion.
- clr_cmd_rdy with cmd_rdy=0 has no effect.
- All error outputs are registered one-cycle pulses and mutually exclusive per event.

Optional Feature:
Macro CMD_CHKSUM_EN.
- Defined: a third byte follows each command. Path is WAIT_HI -> WAIT_LO -> WAIT_CHK.
  - WAIT_CHK has the same timeout rules as WAIT_LO.
  - If checksum byte == high ^ low ^ 8'hFF: complete the command as above.
  - Otherwise: pulse chk_err at T+1, leave cmd/cmd_rdy unchanged, return to WAIT_HI.
- Undefined: WAIT_CHK does not exist, commands are two bytes, and chk_err is constant 0.

Test Plan:
- Basic: bytes 8'h3C then 8'hA5, ~10 cycles apart -> cmd=16'h3CA5 and cmd_rdy=1 one cycle after the second accept; clr_rx_rdy pulses exactly twice; clr_cmd_rdy -> cmd_rdy=0 next cycle.
- Timeout (TIMEOUT_CLKS=100): byte 8'h12, idle 100 cycles -> to_err one-cycle pulse, cmd_rdy stays 0; then 8'h56, 8'h78 -> cmd=16'h5678.
- Overrun: send 16'h1111, no clear, then send 16'h2222 -> ovr_err pulse, cmd=16'h2222, cmd_rdy=1. Repeat with clr_cmd_rdy coincident with the completion -> no ovr_err.
- Reset mid-command: byte 8'hAB, assert rst_n=0 for 2 cycles -> all outputs at reset values; next bytes 8'hCD, 8'hEF -> cmd=16'hCDEF.
- Back-to-back: 4 commands through a real UART_tx/UART_rx pair at 19200 baud -> 4 correct cmd values, no errors.
- CMD_CHKSUM_EN: bytes 8'h0F, 8'hF0, 8'hFF -> chk_err (0x0F^0xF0^0xFF=0x00); then 8'h0F, 8'hF0, 8'h00 -> cmd=16'h0FF0.
